riscv_register_file_sb: RTL and testbench
=========================================

// Module: riscv_register_file_sb
// PURPOSE
//  Parametrised integer/FP register file with NUM_RPORTS read ports, two write ports and a
//  per-register busy scoreboard for long-latency producers (LSU, FPU, divider). Sits in the ID stage.
//  Read ports return data plus a busy flag, so the hazard unit stalls on pending operands.
//  Optional write-to-read bypass removes the WB->ID forwarding path.
// PARAMETERS
//  BANK_AW     5   log2 words per bank (integer bank; FP bank same size)
//  DATA_WIDTH  32  register width
//  FPU         0   1: add FP bank; address MSB selects FP bank
//  NUM_RPORTS  3   number of read ports (1..4)
//  BYPASS      1   1: same-cycle write data forwarded to reads
//  localparam ADDR_WIDTH = BANK_AW+FPU; NUM_TOT = 2**ADDR_WIDTH; CNT_W = $clog2(NUM_TOT)+1
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      asynchronous reset, active low
//  raddr_i    in   NUM_RPORTS*ADDR_WIDTH  read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  rdata_o    out  NUM_RPORTS*DATA_WIDTH  read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  rbusy_o    out  NUM_RPORTS             1 = register addressed on port p has a pending producer
//  waddr_a_i  in   ADDR_WIDTH             write port A (single-cycle ALU results) address
//  wdata_a_i  in   DATA_WIDTH             write port A data
//  we_a_i     in   1                      write port A enable
//  waddr_b_i  in   ADDR_WIDTH             write port B (long-latency writeback) address
//  wdata_b_i  in   DATA_WIDTH             write port B data
//  we_b_i     in   1                      write port B enable; clears busy of waddr_b_i
//  sb_set_i   in   1                      mark sb_addr_i busy (long-latency op issued)
//  sb_addr_i  in   ADDR_WIDTH             destination to mark busy
//  flush_i    in   1                      clear all busy bits (pipeline flush)
//  sb_cnt_o   out  CNT_W                  number of registers currently busy
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all busy bits 0, sb_cnt_o=0. rdata_o/rbusy_o are
//    combinational, so they read 0 during reset. Mid-operation reset drops pending writes/sets.
//  - Integer x0 (address 0): always reads 0, busy always 0. Writes and sb_set to x0 are ignored.
//    FP f0 (address 2**BANK_AW, FPU=1) is a normal register.
//  - Writes: registered at posedge. Same address on A and B in one cycle: B wins.
//    Writing via port A does not change busy.
//  - Reads: combinational from the array, 0-cycle latency.
//    BYPASS=1 with a valid write this cycle to the read address: return write data, B before A.
//    BYPASS=0: return old contents; new value is visible the next cycle.
//  - rbusy_o[p]: BYPASS=1 gives busy[raddr] & ~(we_b_i & waddr_b_i==raddr);
//    BYPASS=0 gives busy[raddr] (registered state).
//  - Scoreboard update at posedge, priority high->low:
//    (1) flush_i: all bits 0; sb_set_i and the B clear are ignored that cycle.
//    (2) sb_set_i to the same address as a we_b_i clear: bit ends 1, since the new producer wins.
//    (3) otherwise set sb_addr_i, clear waddr_b_i; independent addresses both take effect.
//    Setting an already-busy bit is legal and the bit stays 1. Clearing a non-busy bit has no effect.
//  - sb_cnt_o: registered popcount, updated incrementally (+1 new set, -1 effective clear,
//    0 after flush). It must equal the popcount of the busy vector every cycle. Max NUM_TOT-1.
//  - FPU=0: the address is BANK_AW bits; no FP bank logic is generated.
//  - The x0 rules take precedence over all write, bypass and scoreboard rules above.
// TESTING
//  1. Reset, write x5=0xDEAD_BEEF via A -> next cycle all read ports at 5 return 0xDEADBEEF;
//     write x0 -> reads 0.
//  2. A and B both write x7 (0x1111 / 0x2222) in one cycle, BYPASS=1 -> same-cycle read returns
//     0x2222, and x7 holds 0x2222 afterwards.
//  3. sb_set x9, then read port 1 at 9 -> rbusy_o[1]=1, sb_cnt_o=1. Three cycles later we_b x9 ->
//     rbusy 0 in that cycle (BYPASS=1), sb_cnt_o=0 the next cycle.
//  4. In one cycle, sb_set x3 and we_b x3 -> busy[3]=1, sb_cnt_o unchanged at +1. Set x4 with
//     flush_i=1 -> all busy 0, sb_cnt_o=0.
//  5. FPU=1: write addr 0x20 = 0x3F80_0000 and x0 -> rdata at 0x20 returns 0x3F800000, at 0
//     returns 0. sb_set 0x20 -> busy. Random set/clear/flush for 10k cycles: sb_cnt_o == popcount.
//  6. Assert rst_n mid-stream with 5 regs busy -> busy, cnt and data are all 0 asynchronously.

Source files
------------

// File: rtl/riscv_register_file_sb.sv
// Integer/FP register file with multiple combinational read ports, two write ports and a
// per-register busy scoreboard that tracks destinations of long-latency operations.
module riscv_register_file_sb #(
    parameter int BANK_AW    = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int NUM_RPORTS = 3,
    parameter int BYPASS     = 1,
    localparam int ADDR_WIDTH = BANK_AW + FPU,
    localparam int NUM_TOT    = 2 ** ADDR_WIDTH,
    localparam int CNT_W      = $clog2(NUM_TOT) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [ADDR_WIDTH-1:0]            waddr_a_i,
    input  logic [DATA_WIDTH-1:0]            wdata_a_i,
    input  logic                             we_a_i,
    input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
    input  logic [DATA_WIDTH-1:0]            wdata_b_i,
    input  logic                             we_b_i,
    input  logic                             sb_set_i,
    input  logic [ADDR_WIDTH-1:0]            sb_addr_i,
    input  logic                             flush_i,
    output logic [CNT_W-1:0]                 sb_cnt_o
);

    logic [NUM_TOT-1:0][DATA_WIDTH-1:0] rf_words;
    logic [NUM_TOT-1:0]                 busy_reg;
    logic [NUM_TOT-1:0]                 busy_next;
    logic [CNT_W-1:0]                   sb_cnt_reg;
    logic [CNT_W-1:0]                   sb_cnt_next;

    // Storage needs async reset and 0-cycle reads, so each word is a plain flop register.
    // Address 0 is the hardwired integer zero register and has no storage at all.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TOT; gi++) begin : g_word
            if (gi == 0) begin : g_zero
                assign rf_words[gi]  = '0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic [DATA_WIDTH-1:0] word_reg;
                logic                  sel_a;
                logic                  sel_b;
                logic                  set_hit;

                assign sel_a   = we_a_i   && (waddr_a_i == ADDR_WIDTH'(gi));
                assign sel_b   = we_b_i   && (waddr_b_i == ADDR_WIDTH'(gi));
                assign set_hit = sb_set_i && (sb_addr_i == ADDR_WIDTH'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (sel_b) begin
                        word_reg <= wdata_b_i;
                    end else if (sel_a) begin
                        word_reg <= wdata_a_i;
                    end
                end

                assign rf_words[gi] = word_reg;

                // A new producer issued in the same cycle as the old one retires keeps the bit set.
                assign busy_next[gi] = flush_i ? 1'b0 :
                                       set_hit ? 1'b1 :
                                       sel_b   ? 1'b0 : busy_reg[gi];
            end
        end
    endgenerate

    logic set_eff;
    logic clr_eff;
    logic cnt_inc;
    logic cnt_dec;

    assign set_eff = sb_set_i && (sb_addr_i != '0);
    assign clr_eff = we_b_i && (waddr_b_i != '0) && !(set_eff && (sb_addr_i == waddr_b_i));
    assign cnt_inc = set_eff && !busy_reg[sb_addr_i];
    assign cnt_dec = clr_eff && busy_reg[waddr_b_i];

    always_comb begin
        sb_cnt_next = sb_cnt_reg;
        if (flush_i) begin
            sb_cnt_next = '0;
        end else begin
            sb_cnt_next = sb_cnt_reg + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= '0;
            sb_cnt_reg <= '0;
        end else begin
            busy_reg   <= busy_next;
            sb_cnt_reg <= sb_cnt_next;
        end
    end

    assign sb_cnt_o = sb_cnt_reg;

    generate
        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] rd_data;
            logic                  rd_busy;

            assign rd_addr = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

            if (BYPASS != 0) begin : g_bypass
                logic hit_a;
                logic hit_b;

                assign hit_a = we_a_i && (waddr_a_i == rd_addr);
                assign hit_b = we_b_i && (waddr_b_i == rd_addr);

                // Port B is checked last so it overrides A, matching write priority.
                always_comb begin
                    rd_data = rf_words[rd_addr];
                    rd_busy = busy_reg[rd_addr] && !hit_b;
                    if (hit_a) begin
                        rd_data = wdata_a_i;
                    end
                    if (hit_b) begin
                        rd_data = wdata_b_i;
                    end
                    if (rd_addr == '0) begin
                        rd_data = '0;
                        rd_busy = 1'b0;
                    end
                end
            end else begin : g_direct
                always_comb begin
                    rd_data = rf_words[rd_addr];
                    rd_busy = busy_reg[rd_addr];
                    if (rd_addr == '0) begin
                        rd_data = '0;
                        rd_busy = 1'b0;
                    end
                end
            end

            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            assign rbusy_o[gi]                          = rd_busy;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Directed and randomised checks of the register file: one bypassing FP-enabled instance
// and one integer-only instance without bypass.
module tb_riscv_register_file_sb;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int NP  = 3;
    localparam int CW  = 7;
    localparam int NAW = 5;
    localparam int NNP = 2;
    localparam int NCW = 6;

    logic clk;
    logic rst_n;

    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rbusy;
    logic [AW-1:0]    waddr_a, waddr_b, sb_addr;
    logic [DW-1:0]    wdata_a, wdata_b;
    logic             we_a, we_b, sb_set, flush;
    logic [CW-1:0]    sb_cnt;

    logic [NNP*NAW-1:0] nb_raddr;
    logic [NNP*DW-1:0]  nb_rdata;
    logic [NNP-1:0]     nb_rbusy;
    logic [NAW-1:0]     nb_waddr_a, nb_waddr_b, nb_sb_addr;
    logic [DW-1:0]      nb_wdata_a, nb_wdata_b;
    logic               nb_we_a, nb_we_b, nb_sb_set, nb_flush;
    logic [NCW-1:0]     nb_sb_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_register_file_sb #(
        .BANK_AW(5), .DATA_WIDTH(DW), .FPU(1), .NUM_RPORTS(NP), .BYPASS(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr), .flush_i(flush),
        .sb_cnt_o(sb_cnt)
    );

    riscv_register_file_sb #(
        .BANK_AW(5), .DATA_WIDTH(DW), .FPU(0), .NUM_RPORTS(NNP), .BYPASS(0)
    ) u_nb (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(nb_raddr), .rdata_o(nb_rdata), .rbusy_o(nb_rbusy),
        .waddr_a_i(nb_waddr_a), .wdata_a_i(nb_wdata_a), .we_a_i(nb_we_a),
        .waddr_b_i(nb_waddr_b), .wdata_b_i(nb_wdata_b), .we_b_i(nb_we_b),
        .sb_set_i(nb_sb_set), .sb_addr_i(nb_sb_addr), .flush_i(nb_flush),
        .sb_cnt_o(nb_sb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        raddr = '0; waddr_a = '0; wdata_a = '0; we_a = 1'b0;
        waddr_b = '0; wdata_b = '0; we_b = 1'b0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    endtask

    task automatic nb_idle();
        nb_raddr = '0; nb_waddr_a = '0; nb_wdata_a = '0; nb_we_a = 1'b0;
        nb_waddr_b = '0; nb_wdata_b = '0; nb_we_b = 1'b0;
        nb_sb_set = 1'b0; nb_sb_addr = '0; nb_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        nb_idle();
        #3;
        for (int p = 0; p < NP; p++) begin
            n_checks++;
            if (rdata[p*DW +: DW] !== 32'h0) begin
                n_fail++; $display("FAIL reset_rdata port %0d got %h want 0", p, rdata[p*DW +: DW]);
            end
        end
        n_checks++;
        if (rbusy !== 3'b000) begin n_fail++; $display("FAIL reset_rbusy got %b want 000", rbusy); end
        n_checks++;
        if (sb_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", sb_cnt); end
        n_checks++;
        if (nb_sb_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_nb_cnt got %0d want 0", nb_sb_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_write_read();
        logic [AW-1:0] a5 = 6'd5;
        logic [AW-1:0] a0 = 6'd0;
        @(negedge clk);
        idle();
        we_a = 1'b1; waddr_a = a5; wdata_a = 32'hDEAD_BEEF; raddr = {NP{a5}};
        #1;
        n_checks++;
        if (rdata[DW-1:0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_a got %h want deadbeef", rdata[DW-1:0]);
        end
        @(negedge clk);
        idle();
        raddr = {NP{a5}};
        #1;
        for (int p = 0; p < NP; p++) begin
            n_checks++;
            if (rdata[p*DW +: DW] !== 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL read_x5 port %0d got %h want deadbeef", p, rdata[p*DW +: DW]);
            end
        end
        $display("write_read: x5 written via A, read on all ports");
        @(negedge clk);
        idle();
        we_a = 1'b1; waddr_a = a0; wdata_a = 32'h1234_5678; raddr = {NP{a0}};
        #1;
        n_checks++;
        if (rdata[DW-1:0] !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", rdata[DW-1:0]); end
        @(negedge clk);
        idle();
        raddr = {NP{a0}};
        #1;
        n_checks++;
        if (rdata[2*DW +: DW] !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h want 0", rdata[2*DW +: DW]); end
        $display("write_read: x0 write ignored");
    endtask

    task automatic test_same_addr();
        logic [AW-1:0] a7 = 6'd7;
        @(negedge clk);
        idle();
        we_a = 1'b1; waddr_a = a7; wdata_a = 32'h1111;
        we_b = 1'b1; waddr_b = a7; wdata_b = 32'h2222;
        raddr = {NP{a7}};
        #1;
        n_checks++;
        if (rdata[DW +: DW] !== 32'h2222) begin n_fail++; $display("FAIL ab_bypass got %h want 2222", rdata[DW +: DW]); end
        @(negedge clk);
        idle();
        raddr = {NP{a7}};
        #1;
        n_checks++;
        if (rdata[DW-1:0] !== 32'h2222) begin n_fail++; $display("FAIL ab_stored got %h want 2222", rdata[DW-1:0]); end
        $display("same_addr: A and B to x7, B wins");
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_addr = 6'd9; raddr[AW +: AW] = 6'd9;
        #1;
        n_checks++;
        if (rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL sb_pre_busy got %b want 0", rbusy[1]); end
        @(negedge clk);
        idle();
        raddr[AW +: AW] = 6'd9;
        #1;
        n_checks++;
        if (rbusy[1] !== 1'b1) begin n_fail++; $display("FAIL sb_busy got %b want 1", rbusy[1]); end
        n_checks++;
        if (sb_cnt !== 7'd1) begin n_fail++; $display("FAIL sb_cnt_set got %0d want 1", sb_cnt); end
        repeat (2) @(negedge clk);
        we_b = 1'b1; waddr_b = 6'd9; wdata_b = 32'hABCD;
        #1;
        n_checks++;
        if (rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL sb_clear_bypass got %b want 0", rbusy[1]); end
        n_checks++;
        if (sb_cnt !== 7'd1) begin n_fail++; $display("FAIL sb_cnt_hold got %0d want 1", sb_cnt); end
        @(negedge clk);
        idle();
        raddr[AW +: AW] = 6'd9;
        #1;
        n_checks++;
        if (sb_cnt !== 7'd0) begin n_fail++; $display("FAIL sb_cnt_clear got %0d want 0", sb_cnt); end
        n_checks++;
        if (rdata[DW +: DW] !== 32'hABCD) begin n_fail++; $display("FAIL wb_data got %h want abcd", rdata[DW +: DW]); end
        // Retiring a register that is not busy must not underflow the count.
        we_b = 1'b1; waddr_b = 6'd10; wdata_b = 32'h10;
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (sb_cnt !== 7'd0) begin n_fail++; $display("FAIL clr_idle_cnt got %0d want 0", sb_cnt); end
        $display("scoreboard: set x9, retire x9, retire idle x10");
    endtask

    task automatic test_set_clear_same();
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_addr = 6'd3; we_b = 1'b1; waddr_b = 6'd3; wdata_b = 32'h33;
        @(negedge clk);
        idle();
        raddr[AW-1:0] = 6'd3;
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL setclr_busy got %b want 1", rbusy[0]); end
        n_checks++;
        if (sb_cnt !== 7'd1) begin n_fail++; $display("FAIL setclr_cnt got %0d want 1", sb_cnt); end
        sb_set = 1'b1; sb_addr = 6'd3;
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_addr = 6'd0;
        @(negedge clk);
        idle();
        raddr[AW-1:0] = 6'd0;
        #1;
        n_checks++;
        if (sb_cnt !== 7'd1) begin n_fail++; $display("FAIL reset_x3_x0_cnt got %0d want 1", sb_cnt); end
        n_checks++;
        if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b want 0", rbusy[0]); end
        sb_set = 1'b1; sb_addr = 6'd4; flush = 1'b1;
        @(negedge clk);
        idle();
        raddr[AW-1:0] = 6'd3; raddr[AW +: AW] = 6'd4;
        #1;
        n_checks++;
        if (rbusy !== 3'b000) begin n_fail++; $display("FAIL flush_busy got %b want 000", rbusy); end
        n_checks++;
        if (sb_cnt !== 7'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", sb_cnt); end
        $display("set_clear_same: set wins over clear, flush wins over set");
    endtask

    task automatic test_fpu();
        logic [63:0]   busy_m = '0;
        logic [AW-1:0] ra;
        logic          exp_b;
        @(negedge clk);
        idle();
        we_a = 1'b1; waddr_a = 6'h20; wdata_a = 32'h3F80_0000;
        we_b = 1'b1; waddr_b = 6'h00; wdata_b = 32'h55;
        @(negedge clk);
        idle();
        raddr[AW-1:0] = 6'h20; raddr[AW +: AW] = 6'h00;
        #1;
        n_checks++;
        if (rdata[DW-1:0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL f0_read got %h want 3f800000", rdata[DW-1:0]); end
        n_checks++;
        if (rdata[DW +: DW] !== 32'h0) begin n_fail++; $display("FAIL x0_fp_read got %h want 0", rdata[DW +: DW]); end
        sb_set = 1'b1; sb_addr = 6'h20;
        @(negedge clk);
        idle();
        raddr[AW-1:0] = 6'h20;
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL f0_busy got %b want 1", rbusy[0]); end
        flush = 1'b1;
        $display("fpu: f0 read/write and busy");
        @(negedge clk);
        for (int c = 0; c < 10000; c++) begin
            idle();
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = AW'($urandom_range(0, 63));
            we_b    = 1'($urandom_range(0, 1));
            waddr_b = ($urandom_range(0, 1) == 1) ? sb_addr : AW'($urandom_range(0, 63));
            wdata_b = $urandom;
            flush   = ($urandom_range(0, 63) == 0);
            ra      = AW'($urandom_range(0, 63));
            raddr[2*AW +: AW] = ra;
            #1;
            exp_b = busy_m[ra] && !(we_b && waddr_b == ra) && (ra != 6'd0);
            n_checks++;
            if (rbusy[2] !== exp_b) begin
                n_fail++; $display("FAIL rand_rbusy cycle %0d addr %0d got %b want %b", c, ra, rbusy[2], exp_b);
            end
            n_checks++;
            if (sb_cnt !== CW'($countones(busy_m))) begin
                n_fail++; $display("FAIL rand_cnt cycle %0d got %0d want %0d", c, sb_cnt, $countones(busy_m));
            end
            if (flush) begin
                busy_m = '0;
            end else begin
                if (we_b && waddr_b != 6'd0) busy_m[waddr_b] = 1'b0;
                if (sb_set && sb_addr != 6'd0) busy_m[sb_addr] = 1'b1;
            end
            @(negedge clk);
        end
        idle();
        #1;
        n_checks++;
        if (sb_cnt !== CW'($countones(busy_m))) begin
            n_fail++; $display("FAIL rand_cnt_final got %0d want %0d", sb_cnt, $countones(busy_m));
        end
        $display("fpu: random scoreboard run done, final busy %0d", $countones(busy_m));
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        nb_idle();
        nb_we_a = 1'b1; nb_waddr_a = 5'd6; nb_wdata_a = 32'hCAFE; nb_raddr[NAW-1:0] = 5'd6;
        nb_sb_set = 1'b1; nb_sb_addr = 5'd6;
        #1;
        n_checks++;
        if (nb_rdata[DW-1:0] !== 32'h0) begin n_fail++; $display("FAIL nb_old_data got %h want 0", nb_rdata[DW-1:0]); end
        @(negedge clk);
        nb_idle();
        nb_raddr[NAW-1:0] = 5'd6;
        nb_we_b = 1'b1; nb_waddr_b = 5'd6; nb_wdata_b = 32'hBEEF;
        #1;
        n_checks++;
        if (nb_rdata[DW-1:0] !== 32'hCAFE) begin n_fail++; $display("FAIL nb_new_data got %h want cafe", nb_rdata[DW-1:0]); end
        n_checks++;
        if (nb_rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL nb_busy_held got %b want 1", nb_rbusy[0]); end
        n_checks++;
        if (nb_sb_cnt !== 6'd1) begin n_fail++; $display("FAIL nb_cnt got %0d want 1", nb_sb_cnt); end
        @(negedge clk);
        nb_idle();
        nb_raddr[NAW-1:0] = 5'd6;
        #1;
        n_checks++;
        if (nb_rdata[DW-1:0] !== 32'hBEEF) begin n_fail++; $display("FAIL nb_wb_data got %h want beef", nb_rdata[DW-1:0]); end
        n_checks++;
        if (nb_rbusy[0] !== 1'b0 || nb_sb_cnt !== 6'd0) begin
            n_fail++; $display("FAIL nb_retire got busy %b cnt %0d want 0 0", nb_rbusy[0], nb_sb_cnt);
        end
        $display("no_bypass: writes visible next cycle, busy registered");
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] busy_list [5] = '{6'd1, 6'd2, 6'd11, 6'd12, 6'd13};
        @(negedge clk);
        idle();
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            sb_set = 1'b1; sb_addr = busy_list[i];
            if (i == 0) begin we_a = 1'b1; waddr_a = 6'd11; wdata_a = 32'h77; end
        end
        @(negedge clk);
        idle();
        raddr = {6'd13, 6'd12, 6'd11};
        #1;
        n_checks++;
        if (sb_cnt !== 7'd5 || rbusy !== 3'b111 || rdata[DW-1:0] !== 32'h77) begin
            n_fail++; $display("FAIL pre_reset got cnt %0d busy %b data %h want 5 111 77", sb_cnt, rbusy, rdata[DW-1:0]);
        end
        #1;
        we_a = 1'b1; waddr_a = 6'd20; wdata_a = 32'h99; sb_set = 1'b1; sb_addr = 6'd20;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sb_cnt !== 7'd0 || rbusy !== 3'b000 || rdata[DW-1:0] !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got cnt %0d busy %b data %h want 0 000 0", sb_cnt, rbusy, rdata[DW-1:0]);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        raddr = {6'd20, 6'd12, 6'd11};
        #1;
        n_checks++;
        if (sb_cnt !== 7'd0 || rbusy !== 3'b000 || rdata[2*DW +: DW] !== 32'h0) begin
            n_fail++; $display("FAIL reset_drop got cnt %0d busy %b x20 %h want 0 000 0", sb_cnt, rbusy, rdata[2*DW +: DW]);
        end
        $display("async_reset: pending state dropped");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_scoreboard();
        test_set_clear_same();
        test_no_bypass();
        test_fpu();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
